lc3_mem_responder: RTL

//  Target/responder side of the LC-3 memory handshake (MAR, MDR, MIO_EN, R_W -> R).

---
 rtl/lc3_mem_pkg.sv | 15 +
 rtl/lc3_mmio_regs.sv | 80 ++++++++
 rtl/lc3_mem_responder.sv | 93 +++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared types and device register addresses for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

  localparam logic [15:0] KBSR_A = 16'hFE00;
  localparam logic [15:0] KBDR_A = 16'hFE02;
  localparam logic [15:0] DSR_A  = 16'hFE04;
  localparam logic [15:0] DDR_A  = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard/display registers: strobes act at the edge ending DONE, rdata is combinational.
// kb_ready backpressures the keyboard while a character is unread; disp_valid holds until disp_ready.
module lc3_mmio_regs
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_rd_strobe,
  input  logic        i_wr_strobe,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  input  logic        i_kb_valid,
  input  logic [7:0]  i_kb_data,
  output logic        o_kb_ready,
  output logic        o_disp_valid,
  output logic [7:0]  o_disp_data,
  input  logic        i_disp_ready
);

  logic       r_kbsr;
  logic [7:0] r_kbdr;
  logic       r_dsr;
  logic       r_disp_valid;
  logic [7:0] r_disp_data;

  logic w_kb_take;
  logic w_kbdr_rd;
  logic w_ddr_wr;
  logic w_unused_wdata;

  assign w_kb_take      = i_kb_valid & ~r_kbsr;
  assign w_kbdr_rd      = i_rd_strobe & (i_addr == KBDR_A);
  assign w_ddr_wr       = i_wr_strobe & (i_addr == DDR_A);
  assign w_unused_wdata = ^i_wdata[15:8];

  assign o_kb_ready   = ~r_kbsr;
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;

  // A capture can only coincide with a KBDR read when the flag is already clear,
  // so letting the capture win never loses a character.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_kbsr <= 1'b0;
      r_kbdr <= 8'h00;
    end else if (w_kb_take) begin
      r_kbsr <= 1'b1;
      r_kbdr <= i_kb_data;
    end else if (w_kbdr_rd) begin
      r_kbsr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dsr        <= 1'b1;
      r_disp_valid <= 1'b0;
      r_disp_data  <= 8'h00;
    end else if (w_ddr_wr) begin
      r_dsr        <= 1'b0;
      r_disp_valid <= 1'b1;
      r_disp_data  <= i_wdata[7:0];
    end else if (r_disp_valid && i_disp_ready) begin
      r_dsr        <= 1'b1;
      r_disp_valid <= 1'b0;
    end
  end

  always_comb begin
    o_rdata = 16'h0000;
    case (i_addr)
      KBSR_A:  o_rdata = {r_kbsr, 15'b0};
      KBDR_A:  o_rdata = {8'h00, r_kbdr};
      DSR_A:   o_rdata = {r_dsr, 15'b0};
      default: o_rdata = 16'h0000;
    endcase
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// LC-3 memory responder: wait-stated RAM plus MMIO; r pulses LATENCY cycles after a request.
// The initiator holds mio_en until r; back-to-back requests get one idle cycle between them.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter int          LATENCY  = 2,
  parameter logic [15:0] DEV_BASE = 16'hFE00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        r,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  resp_state_t r_state;
  logic [3:0]  r_cnt;
  logic        r_rw;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_mem [0:(2**ADDR_W)-1];

  logic        w_done;
  logic        w_dev;
  logic [15:0] w_ram_q;
  logic [15:0] w_mmio_rdata;

  assign w_done  = (r_state == DONE);
  assign w_dev   = (r_addr >= DEV_BASE);
  assign w_ram_q = r_mem[r_addr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (mio_en) begin
            r_rw    <= r_w;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM is not reset; the rstn gate only stops an access aborted in DONE from committing.
  always_ff @(posedge clk) begin
    if (rstn && w_done && r_rw && !w_dev) r_mem[r_addr[ADDR_W-1:0]] <= r_wdata;
  end

  lc3_mmio_regs u_mmio (
    .clk          (clk),
    .rstn         (rstn),
    .i_rd_strobe  (w_done & ~r_rw & w_dev),
    .i_wr_strobe  (w_done & r_rw & w_dev),
    .i_addr       (r_addr),
    .i_wdata      (r_wdata),
    .o_rdata      (w_mmio_rdata),
    .i_kb_valid   (kb_valid),
    .i_kb_data    (kb_data),
    .o_kb_ready   (kb_ready),
    .o_disp_valid (disp_valid),
    .o_disp_data  (disp_data),
    .i_disp_ready (disp_ready)
  );

  assign r     = w_done;
  assign rdata = w_done ? (w_dev ? w_mmio_rdata : w_ram_q) : 16'h0000;

endmodule
